// File: rtl/if_id_buffer_if.sv
// Fetch-to-decode bus for the IF/ID pipeline buffer.
// The master side is the fetch stage plus pipeline control;
// the slave side is the buffer that assembles instructions for decode.
interface if_id_buffer_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned INSTR_W = 16
);

   // Fetch side
   logic [INSTR_W-1:0] instr_in;
   logic [ADDR_W-1:0]  pc_in;
   logic               fetch_valid;

   // Pipeline control
   logic               stall;
   logic               flush;

   // Decode side
   logic [INSTR_W-1:0] instr_out;
   logic [INSTR_W-1:0] imm_out;
   logic [ADDR_W-1:0]  pc_out;
   logic [1:0]         len_out;
   logic               valid_out;

   modport master (
      output instr_in, pc_in, fetch_valid, stall, flush,
      input  instr_out, imm_out, pc_out, len_out, valid_out
   );

   modport slave (
      input  instr_in, pc_in, fetch_valid, stall, flush,
      output instr_out, imm_out, pc_out, len_out, valid_out
   );

endinterface

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer. Collects one- or two-word instructions from the
// fetch stage and presents each complete instruction to decode for one
// cycle. An opcode word with LONG_BIT set is followed by an immediate word.
// Priority each cycle: flush, then stall, then fetch_valid.
module if_id_buffer #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned INSTR_W  = 16,
   parameter int unsigned LONG_BIT = 15
) (
   input  logic           clk,
   input  logic           rst,
   if_id_buffer_if.slave  bus
);

   typedef enum logic {
      FIRST  = 1'b0,
      SECOND = 1'b1
   } state_t;

   state_t             state_q, state_n;
   logic [INSTR_W-1:0] instr_q, instr_n;
   logic [INSTR_W-1:0] imm_q,   imm_n;
   logic [ADDR_W-1:0]  pc_q,    pc_n;
   logic [1:0]         len_q,   len_n;
   logic               valid_q, valid_n;

   logic               is_long;

   assign is_long = bus.instr_in[LONG_BIT];

   // State and output registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FIRST;
         instr_q <= '0;
         imm_q   <= '0;
         pc_q    <= '0;
         len_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         instr_q <= instr_n;
         imm_q   <= imm_n;
         pc_q    <= pc_n;
         len_q   <= len_n;
         valid_q <= valid_n;
      end
   end

   // Next-state and next-output selection: hold by default, then apply
   // flush / stall / fetch in priority order.
   always_comb begin
      state_n = state_q;
      instr_n = instr_q;
      imm_n   = imm_q;
      pc_n    = pc_q;
      len_n   = len_q;
      valid_n = valid_q;

      if (bus.flush) begin
         // Drop any half-built instruction; pc_out keeps its last value.
         state_n = FIRST;
         instr_n = '0;
         imm_n   = '0;
         len_n   = '0;
         valid_n = 1'b0;
      end else if (bus.stall) begin
         // Everything, valid_out included, is frozen.
      end else begin
         valid_n = 1'b0;
         if (bus.fetch_valid) begin
            unique case (state_q)
               FIRST: begin
                  instr_n = bus.instr_in;
                  pc_n    = bus.pc_in;
                  imm_n   = '0;
                  if (is_long) begin
                     len_n   = 2'd2;
                     state_n = SECOND;
                  end else begin
                     len_n   = 2'd1;
                     valid_n = 1'b1;
                  end
               end
               SECOND: begin
                  // Immediate word completes the instruction; its address
                  // is not checked against the opcode address.
                  imm_n   = bus.instr_in;
                  valid_n = 1'b1;
                  state_n = FIRST;
               end
               default: state_n = FIRST;
            endcase
         end
      end
   end

   assign bus.instr_out = instr_q;
   assign bus.imm_out   = imm_q;
   assign bus.pc_out    = pc_q;
   assign bus.len_out   = len_q;
   assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for the IF/ID buffer.
module tb_if_id_buffer;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int unsigned compared   = 0;
   int unsigned mismatched = 0;

   if_id_buffer_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

   if_id_buffer #(.ADDR_W(32), .INSTR_W(16), .LONG_BIT(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [15:0] ins,
                          input logic [15:0] imm, input logic [31:0] pc, input logic [1:0] len);
      chk({tag, ".valid"}, 32'(bus.valid_out), 32'(v));
      chk({tag, ".instr"}, 32'(bus.instr_out), 32'(ins));
      chk({tag, ".imm"},   32'(bus.imm_out),   32'(imm));
      chk({tag, ".pc"},    bus.pc_out,         pc);
      chk({tag, ".len"},   32'(bus.len_out),   32'(len));
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic fv, input logic [15:0] ins, input logic [31:0] pc);
      bus.fetch_valid = fv;
      bus.instr_in    = ins;
      bus.pc_in       = pc;
   endtask

   initial begin
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      drive(1'b0, 16'h0, 32'h0);

      // Reset state, held through clock edges
      step();
      step();
      chk_all("reset", 1'b0, 16'h0, 16'h0, 32'h0, 2'd0);
      rst = 1'b1;
      step();
      chk_all("post_reset_idle", 1'b0, 16'h0, 16'h0, 32'h0, 2'd0);

      // One-word instruction
      drive(1'b1, 16'h0070, 32'h20);
      step();
      chk_all("one_word", 1'b1, 16'h0070, 16'h0, 32'h20, 2'd1);

      // Two-word instruction
      drive(1'b1, 16'h8071, 32'h21);
      step();
      chk_all("two_word_first", 1'b0, 16'h8071, 16'h0, 32'h21, 2'd2);
      drive(1'b1, 16'h1234, 32'h22);
      step();
      chk_all("two_word_done", 1'b1, 16'h8071, 16'h1234, 32'h21, 2'd2);
      drive(1'b0, 16'hDEAD, 32'h99);
      step();
      chk_all("idle_hold", 1'b0, 16'h8071, 16'h1234, 32'h21, 2'd2);

      // Stall freezes a valid instruction for 3 cycles
      drive(1'b1, 16'h0075, 32'h23);
      step();
      chk_all("pre_stall", 1'b1, 16'h0075, 16'h0, 32'h23, 2'd1);
      bus.stall = 1'b1;
      drive(1'b1, 16'h0076, 32'h24);
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("stall%0d", i), 1'b1, 16'h0075, 16'h0, 32'h23, 2'd1);
      end
      bus.stall = 1'b0;
      step();
      chk_all("after_stall", 1'b1, 16'h0076, 16'h0, 32'h24, 2'd1);

      // Flush beats stall and discards a half-built instruction
      drive(1'b1, 16'h8072, 32'h30);
      step();
      chk_all("flush_pre", 1'b0, 16'h8072, 16'h0, 32'h30, 2'd2);
      bus.flush = 1'b1;
      bus.stall = 1'b1;
      drive(1'b1, 16'h1111, 32'h31);
      step();
      chk_all("flush", 1'b0, 16'h0, 16'h0, 32'h30, 2'd0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;
      drive(1'b1, 16'h0073, 32'h31);
      step();
      chk_all("after_flush", 1'b1, 16'h0073, 16'h0, 32'h31, 2'd1);

      // SECOND waits indefinitely for the immediate word
      drive(1'b1, 16'h8077, 32'h40);
      step();
      drive(1'b0, 16'h0, 32'h0);
      step();
      step();
      chk_all("second_wait", 1'b0, 16'h8077, 16'h0, 32'h40, 2'd2);
      drive(1'b1, 16'h5555, 32'h41);
      step();
      chk_all("second_late", 1'b1, 16'h8077, 16'h5555, 32'h40, 2'd2);

      // Maximum pc value passes unchanged
      drive(1'b1, 16'h0079, 32'hFFFF_FFFF);
      step();
      chk_all("pc_max", 1'b1, 16'h0079, 16'h0, 32'hFFFF_FFFF, 2'd1);

      // Asynchronous reset mid-cycle while in SECOND
      drive(1'b1, 16'h8078, 32'h50);
      step();
      chk_all("rst_pre", 1'b0, 16'h8078, 16'h0, 32'h50, 2'd2);
      drive(1'b0, 16'h0, 32'h0);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 16'h0, 16'h0, 32'h0, 2'd0);
      step();
      rst = 1'b1;
      drive(1'b1, 16'h0074, 32'h51);
      step();
      chk_all("after_rst", 1'b1, 16'h0074, 16'h0, 32'h51, 2'd1);

      // Five back-to-back one-word instructions
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 16'h0080 + 16'(i), 32'h20 + 32'(i));
         step();
         chk_all($sformatf("b2b%0d", i), 1'b1, 16'h0080 + 16'(i), 16'h0, 32'h20 + 32'(i), 2'd1);
      end
      drive(1'b0, 16'h0, 32'h0);
      step();
      chk("b2b_end.valid", 32'(bus.valid_out), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/if_id_buffer.md
IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter: ADDR_W, 32, width of program-counter values.
REQ-002 Parameter: INSTR_W, 16, width of one instruction-memory word.
REQ-003 Parameter: LONG_BIT, 15, bit of the opcode word that marks a two-word (immediate) instruction when 1.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: instr_in  input  INSTR_W  word just read from instruction memory by the fetch stage.
REQ-007 Port: pc_in  input  ADDR_W  word address of instr_in.
REQ-008 Port: fetch_valid  input  1  instr_in/pc_in are valid this cycle.
REQ-009 Port: stall  input  1  decode cannot accept; hold all contents.
REQ-010 Port: flush  input  1  branch/jump taken; discard contents.
REQ-011 Port: instr_out  output  INSTR_W  opcode word presented to decode.
REQ-012 Port: imm_out  output  INSTR_W  immediate word of a two-word instruction, else 0.
REQ-013 Port: pc_out  output  ADDR_W  address of the opcode word in instr_out.
REQ-014 Port: len_out  output  2  instruction length in words (1 or 2).
REQ-015 Port: valid_out  output  1  instr_out/imm_out/pc_out/len_out form a complete instruction.

Function
REQ-016 Two states: FIRST (expecting opcode word), SECOND (expecting immediate word).
REQ-017 Priority per cycle: flush > stall > fetch_valid.
REQ-018 flush: next cycle state=FIRST, valid_out=0, instr_out=0, imm_out=0, len_out=0; pc_out holds; any half-assembled instruction is discarded.
REQ-019 stall (no flush): state and all outputs, including valid_out, hold unchanged; fetch_valid ignored.
REQ-020 FIRST, fetch_valid=1, instr_in[LONG_BIT]=0: next cycle instr_out=instr_in, pc_out=pc_in, imm_out=0, len_out=1, valid_out=1, state stays FIRST.
REQ-021 FIRST, fetch_valid=1, instr_in[LONG_BIT]=1: next cycle instr_out=instr_in, pc_out=pc_in, imm_out=0, len_out=2, valid_out=0, state=SECOND.
REQ-022 SECOND, fetch_valid=1: next cycle imm_out=instr_in, valid_out=1, state=FIRST; instr_out, pc_out, len_out hold; pc_in not checked for contiguity.
REQ-023 Either state, fetch_valid=0, no stall/flush: valid_out=0 next cycle; state and data outputs hold (SECOND keeps waiting indefinitely).
REQ-024 valid_out is high for exactly one cycle per completed instruction unless stall holds it.
REQ-025 Latency: one-word instruction visible 1 cycle after its fetch; two-word instruction visible 1 cycle after its second word.
REQ-026 pc values pass unmodified; no arithmetic on addresses; pc_in of maximum value (all ones) handled like any other.
REQ-027 Back-to-back one-word instructions with fetch_valid held high give valid_out=1 every cycle.

Reset
REQ-028 rst=0 asynchronously forces state=FIRST, instr_out=0, imm_out=0, pc_out=0, len_out=0, valid_out=0, independent of clk.
REQ-029 Reset during SECOND discards the partial instruction; first cycle after release treats instr_in as an opcode word.
REQ-030 Outputs remain at reset values until the first qualifying fetch after rst returns to 1.

Verification
REQ-031 Reset, then fetch_valid=1, instr_in=16'h0070, pc_in=32'h20 -> next cycle valid_out=1, instr_out=16'h0070, pc_out=32'h20, imm_out=0, len_out=1.
REQ-032 instr_in=16'h8071 @pc 32'h21, then 16'h1234 @pc 32'h22 -> after first: valid_out=0; after second: valid_out=1, instr_out=16'h8071, imm_out=16'h1234, pc_out=32'h21, len_out=2.
REQ-033 Valid one-word instruction, then stall=1 for 3 cycles with new words on instr_in -> outputs and valid_out=1 frozen all 3 cycles; next word accepted after stall drops.
REQ-034 Opcode 16'h8072 accepted (state SECOND), then flush=1 with stall=1 -> next cycle valid_out=0, instr_out=0, len_out=0; following word 16'h0073 completes as a one-word instruction.
REQ-035 rst pulled low mid-cycle while state=SECOND -> outputs zero immediately without a clock edge; after release, 16'h0074 emits as one-word instruction.
REQ-036 Five consecutive one-word instructions, fetch_valid continuously high -> five consecutive valid_out=1 cycles with matching pc_out 32'h20..32'h24.
